// File: rtl/y_alu_seq.sv
// y_alu_seq: multi-cycle ALU. Single-cycle logic/arithmetic ops run through
// EXEC; unsigned multiply runs as a WIDTH-cycle shift-add in MUL. The result
// and its flags are registered and held until the next operation completes.
module y_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             zero,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   z_q, z_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   sum, diff, exec_z;
    logic               exec_ovf, slt_bit;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_step;

    // Single-cycle datapath on the latched operands; SLT uses the sign of a
    // when signs differ so it stays correct when a-b overflows.
    always_comb begin
        sum      = a_q + b_q;
        diff     = a_q - b_q;
        slt_bit  = (a_q[WIDTH-1] != b_q[WIDTH-1]) ? a_q[WIDTH-1] : diff[WIDTH-1];
        exec_z   = '0;
        exec_ovf = 1'b0;
        case (op_q)
            OP_AND: exec_z = a_q & b_q;
            OP_OR:  exec_z = a_q | b_q;
            OP_NOR: exec_z = ~(a_q | b_q);
            OP_XOR: exec_z = a_q ^ b_q;
            OP_ADD: begin
                exec_z   = sum;
                exec_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                exec_z   = diff;
                exec_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SLT: exec_z = {{(WIDTH-1){1'b0}}, slt_bit};
            default: begin
                exec_z   = '0;
                exec_ovf = 1'b0;
            end
        endcase
    end

    // One shift-add step: the low half holds the remaining multiplier bits,
    // the high half accumulates a, and the whole thing shifts right each cycle.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        acc_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};
    end

    // Next-state, operand capture and result registration.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d  = a;
                    b_d  = b;
                    op_d = op;
                    if (op == OP_MUL) begin
                        acc_d   = {{WIDTH{1'b0}}, b};
                        cnt_d   = '0;
                        state_d = MUL;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                z_d     = exec_z;
                zero_d  = (exec_z == '0);
                ovf_d   = exec_ovf;
                state_d = DONE;
            end
            MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    z_d     = acc_step[WIDTH-1:0];
                    zero_d  = (acc_step[WIDTH-1:0] == '0);
                    ovf_d   = (acc_step[2*WIDTH-1:WIDTH] != '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset that overrides any transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign z    = z_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule
